// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes: 1-cycle logic/arith ops plus iterative
// shift-add MUL and restoring DIVU/REMU taking WIDTH steps in the CALC state.
module seq_alu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SEL_W = 4,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inValid,
   output logic             inReady,
   input  logic [SEL_W-1:0] aluSel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy
);

   localparam logic [SEL_W-1:0] OpNoop = SEL_W'(0);
   localparam logic [SEL_W-1:0] OpMov  = SEL_W'(1);
   localparam logic [SEL_W-1:0] OpNot  = SEL_W'(2);
   localparam logic [SEL_W-1:0] OpAdd  = SEL_W'(3);
   localparam logic [SEL_W-1:0] OpSub  = SEL_W'(4);
   localparam logic [SEL_W-1:0] OpOr   = SEL_W'(5);
   localparam logic [SEL_W-1:0] OpAnd  = SEL_W'(6);
   localparam logic [SEL_W-1:0] OpSlt  = SEL_W'(7);
   localparam logic [SEL_W-1:0] OpLi   = SEL_W'(8);
   localparam logic [SEL_W-1:0] OpLui  = SEL_W'(9);
   localparam logic [SEL_W-1:0] OpBlt  = SEL_W'(10);
   localparam logic [SEL_W-1:0] OpBle  = SEL_W'(11);
   localparam logic [SEL_W-1:0] OpXor  = SEL_W'(12);
   localparam logic [SEL_W-1:0] OpMul  = SEL_W'(13);
   localparam logic [SEL_W-1:0] OpDivu = SEL_W'(14);
   localparam logic [SEL_W-1:0] OpRemu = SEL_W'(15);

   localparam logic [1:0] KindMul  = 2'b01;
   localparam logic [1:0] KindDivu = 2'b10;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q, single_res, iter_res;
   logic             zero_q;
   logic [1:0]       kind_q;
   logic [CNT_W-1:0] cnt_q;
   // acc: product or partial remainder; opnd: multiplicand or divisor;
   // sh: multiplier or dividend/quotient shift register
   logic [WIDTH-1:0] acc_q, opnd_q, sh_q;
   logic [WIDTH-1:0] mul_acc_nxt, rem_nxt, quot_nxt;
   logic [WIDTH:0]   shifted, diff;
   logic             accept, is_iter, last, ge;

   assign accept  = inValid && (state_q == StIdle);
   assign is_iter = (aluSel == OpMul) || (aluSel == OpDivu) || (aluSel == OpRemu);
   assign last    = (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (accept) state_d = is_iter ? StCalc : StDone;
         StCalc:  if (last) state_d = StDone;
         StDone:  if (outReady) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      inReady  = (state_q == StIdle);
      busy     = (state_q == StCalc);
      outValid = (state_q == StDone);
      result   = result_q;
      zero     = zero_q;
   end

   always_comb begin
      single_res = '0;
      case (aluSel)
         OpNoop:  single_res = result_q;
         OpMov:   single_res = a;
         OpNot:   single_res = ~a;
         OpAdd:   single_res = a + b;
         OpSub:   single_res = a - b;
         OpOr:    single_res = a | b;
         OpAnd:   single_res = a & b;
         OpSlt:   single_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
         OpLi:    single_res = b;
         OpLui:   single_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         OpBlt:   single_res = (a < b) ? '0 : WIDTH'(1);
         OpBle:   single_res = (a <= b) ? '0 : WIDTH'(1);
         OpXor:   single_res = a ^ b;
         default: single_res = '0;
      endcase
   end

   // One iteration of each algorithm; the divide step never overflows bit WIDTH
   always_comb begin
      mul_acc_nxt = sh_q[0] ? (acc_q + opnd_q) : acc_q;
      shifted     = {acc_q, sh_q[WIDTH-1]};
      diff        = shifted - {1'b0, opnd_q};
      ge          = ~diff[WIDTH];
      rem_nxt     = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quot_nxt    = {sh_q[WIDTH-2:0], ge};
      if (kind_q == KindMul)       iter_res = mul_acc_nxt;
      else if (kind_q == KindDivu) iter_res = quot_nxt;
      else                         iter_res = rem_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         zero_q   <= 1'b1;
         kind_q   <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         sh_q     <= '0;
      end else if (accept) begin
         if (is_iter) begin
            kind_q <= aluSel[1:0];
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= (aluSel == OpMul) ? a : b;
            sh_q   <= (aluSel == OpMul) ? b : a;
         end else begin
            result_q <= single_res;
            zero_q   <= (single_res == '0);
         end
      end else if (state_q == StCalc) begin
         cnt_q <= cnt_q + 1'b1;
         if (kind_q == KindMul) begin
            acc_q  <= mul_acc_nxt;
            opnd_q <= opnd_q << 1;
            sh_q   <= sh_q >> 1;
         end else begin
            acc_q <= rem_nxt;
            sh_q  <= quot_nxt;
         end
         if (last) begin
            result_q <= iter_res;
            zero_q   <= (iter_res == '0);
         end
      end
   end

endmodule
